mem_responder: RTL and testbench

Memory-side responder for the LC-3 datapath's MAR/MDR memory port. It accepts read and write requests from the control unit's memory strobes and services them against an internal word-addressed RAM after a programmable number of wait states. It returns read data on `MDR_In` together with a one-cycle ready pulse `R`. With the I/O feature enabled, it also decodes address xFFFF as memory-mapped switches (read) and hex display (write).

---
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// LC-3 MAR/MDR memory responder: word RAM with programmable wait states and a one-cycle R pulse.
// Define MEM_RESPONDER_MMIO_EN to decode xFFFF as SW (read) / HEX (write).
module mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    input  logic [15:0] SW,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] HEX,
    output logic        BUSY
);

`ifdef MEM_RESPONDER_MMIO_EN
    localparam logic IO_EN = 1'b1;
`else
    localparam logic IO_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                we_q, we_d;
    logic                io_q, io_d;
    logic [15:0]         mdr_q, mdr_d;
    logic [15:0]         hex_q, hex_d;
    logic                r_q, r_d;
    logic                ram_we;

    logic [15:0] mem [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        io_d    = io_q;
        mdr_d   = mdr_q;
        hex_d   = hex_q;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_WE | MEM_OE) begin
                    addr_d  = MAR[ADDR_W-1:0];
                    data_d  = MDR;
                    we_d    = MEM_WE;
                    // the I/O decision is made at latch time so only ADDR_W address bits are kept
                    io_d    = IO_EN & (MAR == 16'hFFFF);
                    cnt_d   = WAIT_CNT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (we_q) begin
                        if (io_q) hex_d  = data_q;
                        else      ram_we = 1'b1;
                    end else begin
                        mdr_d = io_q ? SW : mem[addr_q];
                    end
                end
            end
            RESP:    state_d = (MEM_OE | MEM_WE) ? RELEASE : IDLE;
            RELEASE: if (!MEM_OE && !MEM_WE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        r_d = (state_d == RESP);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            mdr_q   <= '0;
            hex_q   <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            io_q    <= io_d;
            mdr_q   <= mdr_d;
            hex_q   <= hex_d;
            r_q     <= r_d;
        end
    end

    // RAM contents survive reset; ram_we is gated by state so a reset drops pending writes
    always_ff @(posedge Clk) begin
        if (ram_we) mem[addr_q] <= data_q;
    end

    assign MDR_In = mdr_q;
    assign R      = r_q;
    assign HEX    = hex_q;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: edge-timeline model plus directed literal checks.
module tb_mem_responder;

`ifdef MEM_RESPONDER_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] MAR = '0, MDR = '0, SW = '0;
    logic        MEM_OE = 1'b0, MEM_WE = 1'b0;
    logic [15:0] MDR_In, HEX;
    logic        R, BUSY;

    int tests = 0;
    int fails = 0;
    int r_pulses = 0;

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR),
        .MEM_OE(MEM_OE), .MEM_WE(MEM_WE), .SW(SW),
        .MDR_In(MDR_In), .R(R), .HEX(HEX), .BUSY(BUSY)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a request seen while idle completes W+1 edges later; R follows for one cycle.
    logic [15:0] mram [1024];
    logic [15:0] exp_mdr = '0, exp_hex = '0;
    logic        exp_r = 1'b0, exp_busy = 1'b0;
    bit          m_active = 1'b0, m_release = 1'b0;
    bit          m_we;
    logic [15:0] m_addr, m_data;
    int          cyc = 0, m_done = 0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_active = 0; m_release = 0;
            exp_r = 0; exp_busy = 0; exp_mdr = '0; exp_hex = '0;
        end else begin
            cyc++;
            exp_r = 0;
            if (m_release) begin
                if (!MEM_OE && !MEM_WE) m_release = 0;
            end else if (m_active) begin
                if (cyc == m_done) begin
                    if (m_we) begin
                        if (MMIO && m_addr == 16'hFFFF) exp_hex = m_data;
                        else mram[int'(m_addr) % 1024] = m_data;
                    end else begin
                        exp_mdr = (MMIO && m_addr == 16'hFFFF) ? SW : mram[int'(m_addr) % 1024];
                    end
                    exp_r = 1;
                end else if (cyc == m_done + 1) begin
                    m_active = 0;
                    m_release = MEM_OE || MEM_WE;
                end
            end else if (MEM_OE || MEM_WE) begin
                m_active = 1;
                m_done = cyc + W + 1;
                m_we = MEM_WE;
                m_addr = MAR;
                m_data = MDR;
            end
            exp_busy = m_active || m_release;
        end
    end

    always @(negedge Clk) begin
        check("R", {15'd0, R}, {15'd0, exp_r});
        check("BUSY", {15'd0, BUSY}, {15'd0, exp_busy});
        check("MDR_In", MDR_In, exp_mdr);
        check("HEX", HEX, exp_hex);
        if (R) r_pulses++;
    end

    task automatic access(input logic we, input logic oe, input logic [15:0] addr,
                          input logic [15:0] data, input int hold, output int lat);
        @(negedge Clk);
        MAR = addr; MDR = data; MEM_WE = we; MEM_OE = oe;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (R) begin lat = n; break; end
        end
        if (lat == 0) check("R_timeout", 16'd0, 16'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            check("hold_busy", {15'd0, BUSY}, 16'd1);
        end
        MEM_WE = 1'b0; MEM_OE = 1'b0;
        for (int n = 0; n < 20 && BUSY; n++) @(negedge Clk);
        if (BUSY) check("idle_timeout", 16'd1, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        #12;
        check("rst_MDR_In", MDR_In, 16'h0000);
        check("rst_HEX", HEX, 16'h0000);
        check("rst_R", {15'd0, R}, 16'd0);
        check("rst_BUSY", {15'd0, BUSY}, 16'd0);
        #10 Reset = 1'b1;

        access(1, 0, 16'h0005, 16'h5555, 0, lat);
        access(1, 0, 16'h0010, 16'hBEEF, 0, lat);
        access(0, 1, 16'h0010, 16'h0000, 0, lat);
        check("read_latency", 16'(lat), 16'd4);
        check("read_beef", MDR_In, 16'hBEEF);

        // reset mid-ACCESS drops the write
        @(negedge Clk);
        p0 = r_pulses;
        MAR = 16'h0005; MDR = 16'h1234; MEM_WE = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b0; MEM_WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("abort_no_R", 16'(r_pulses - p0), 16'd0);
        check("abort_HEX", HEX, 16'h0000);
        check("abort_MDR_In", MDR_In, 16'h0000);
        access(0, 1, 16'h0005, 16'h0000, 0, lat);
        check("abort_ram_kept", MDR_In, 16'h5555);

        access(1, 0, 16'h0400, 16'hA5A5, 0, lat);
        access(0, 1, 16'h0000, 16'h0000, 0, lat);
        check("alias_read", MDR_In, 16'hA5A5);

        access(1, 0, 16'h03FF, 16'h1111, 0, lat);
        SW = 16'h00FF;
        access(0, 1, 16'hFFFF, 16'h0000, 0, lat);
        check("ffff_read", MDR_In, MMIO ? 16'h00FF : 16'h1111);
        access(1, 0, 16'hFFFF, 16'h0042, 0, lat);
        check("ffff_write_hex", HEX, MMIO ? 16'h0042 : 16'h0000);
        access(0, 1, 16'h03FF, 16'h0000, 0, lat);
        check("ram_3ff", MDR_In, MMIO ? 16'h1111 : 16'h0042);

        p0 = r_pulses;
        access(0, 1, 16'h0010, 16'h0000, 10, lat);
        repeat (3) @(negedge Clk);
        check("held_one_pulse", 16'(r_pulses - p0), 16'd1);
        check("held_read", MDR_In, 16'hBEEF);

        access(1, 1, 16'h0020, 16'h7777, 0, lat);
        check("both_is_write_mdr", MDR_In, 16'hBEEF);
        access(0, 1, 16'h0020, 16'h0000, 0, lat);
        check("both_wrote", MDR_In, 16'h7777);
        check("final_latency", 16'(lat), 16'd4);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
